// File: rtl/lcd_pkg.sv
// Shared types and constants for the character-LCD text engine:
// FSM state encoding, bus word field positions, controller init
// commands and the DDRAM row base addresses.
package lcd_pkg;

  typedef enum logic [2:0] {S_PWRUP, S_INIT, S_ADDR, S_CHAR, S_WAIT} state_e;

  // Bus word layout: {RS, RW, DB7..DB0}
  localparam int unsigned RS_BIT = 9;
  localparam int unsigned RW_BIT = 8;

  localparam int unsigned NUM_INIT_CMDS = 6;

  localparam logic [9:0] CMD_FUNC_SET   = 10'h038;
  localparam logic [9:0] CMD_DISP_OFF   = 10'h008;
  localparam logic [9:0] CMD_CLEAR      = 10'h001;
  localparam logic [9:0] CMD_DISP_ON    = 10'h00C;
  localparam logic [9:0] CMD_ENTRY_MODE = 10'h006;

  // Controller init sequence, issued in index order after power-up.
  function automatic logic [9:0] init_cmd(input logic [2:0] idx);
    case (idx)
      3'd0:    return CMD_FUNC_SET;
      3'd1:    return CMD_FUNC_SET;
      3'd2:    return CMD_DISP_OFF;
      3'd3:    return CMD_CLEAR;
      3'd4:    return CMD_DISP_ON;
      3'd5:    return CMD_ENTRY_MODE;
      default: return 10'h000;
    endcase
  endfunction

  // DDRAM address of column 0 for each display row.
  function automatic logic [6:0] row_base(input logic [1:0] row);
    case (row)
      2'd0:    return 7'h00;
      2'd1:    return 7'h40;
      2'd2:    return 7'h14;
      default: return 7'h54;
    endcase
  endfunction

endpackage

// File: rtl/lcd_bus_timer.sv
// Shared LCD bus transaction timer. A start pulse latches the 10-bit word onto
// lcd_flag, raises lcd_en for EN_PULSE_CYC cycles and holds the word for
// CMD_WAIT_CYC cycles in total.
module lcd_bus_timer #(
  parameter int unsigned CMD_WAIT_CYC = 100000,
  parameter int unsigned EN_PULSE_CYC = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [9:0] word,
  output logic       lcd_en,
  output logic [9:0] lcd_flag,
  output logic       done
);

  localparam int unsigned CntW = (CMD_WAIT_CYC > 1) ? $clog2(CMD_WAIT_CYC) : 1;
  localparam logic [CntW-1:0] LastCnt   = CntW'(CMD_WAIT_CYC - 1);
  localparam logic [CntW-1:0] DoneCnt   = CntW'(CMD_WAIT_CYC - 2);
  localparam logic [CntW-1:0] EnLastCnt = CntW'(EN_PULSE_CYC - 1);

  logic            busy_q, busy_d;
  logic            en_q, en_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [9:0]      flag_q, flag_d;

  // Next-state: load on start, otherwise count through the transaction.
  always_comb begin
    busy_d = busy_q;
    en_d   = en_q;
    cnt_d  = cnt_q;
    flag_d = flag_q;
    if (start) begin
      busy_d = 1'b1;
      en_d   = 1'b1;
      cnt_d  = '0;
      flag_d = word;
    end else if (busy_q) begin
      cnt_d = cnt_q + CntW'(1);
      if (cnt_q == EnLastCnt) en_d = 1'b0;
      if (cnt_q == LastCnt) busy_d = 1'b0;
    end
  end

  // Timer state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q <= 1'b0;
      en_q   <= 1'b0;
      cnt_q  <= '0;
      flag_q <= '0;
    end else begin
      busy_q <= busy_d;
      en_q   <= en_d;
      cnt_q  <= cnt_d;
      flag_q <= flag_d;
    end
  end

  assign lcd_en   = en_q;
  assign lcd_flag = flag_q;
  // Fires two cycles before the end so the FSM's one-cycle issue state lines
  // the next start up with the last cycle: transactions run back-to-back.
  assign done     = busy_q && (cnt_q == DoneCnt);

endmodule

// File: rtl/lcd_text_engine.sv
// HD44780-class character-LCD driver with an internal ROWS x COLS frame
// buffer. Handles power-up delay, controller init and continuous refresh.
// Optional build macro LCD_DIRTY_SKIP_EN: per-row dirty bits, clean rows are
// skipped and the refresh idles once everything is clean.
module lcd_text_engine
  import lcd_pkg::*;
#(
  parameter int unsigned ROWS         = 2,
  parameter int unsigned COLS         = 16,
  parameter int unsigned POWERUP_CYC  = 2250000,
  parameter int unsigned CMD_WAIT_CYC = 100000,
  parameter int unsigned EN_PULSE_CYC = 25
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      wr_en,
  input  logic [(ROWS > 1 ? $clog2(ROWS) : 1)-1:0]  wr_row,
  input  logic [(COLS > 1 ? $clog2(COLS) : 1)-1:0]  wr_col,
  input  logic [7:0]                                wr_char,
  input  logic                                      clear,
  output logic                                      lcd_on,
  output logic                                      lcd_en,
  output logic [9:0]                                lcd_flag,
  output logic                                      init_done,
  output logic                                      frame_done
);

  localparam int unsigned RowW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned ColW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned PwrW = (POWERUP_CYC > 1) ? $clog2(POWERUP_CYC) : 1;
  localparam logic [RowW-1:0] RowLast = RowW'(ROWS - 1);
  localparam logic [ColW-1:0] ColLast = ColW'(COLS - 1);

  state_e          state_q, state_d, ret_q, ret_d;
  logic [PwrW-1:0] pwr_cnt_q, pwr_cnt_d;
  logic [2:0]      init_idx_q, init_idx_d;
  logic [RowW-1:0] row_q, row_d;
  logic [ColW-1:0] col_q, col_d;
  logic            init_done_q, init_done_d;
  logic            frame_pend_q, frame_pend_d;
  logic            frame_done_q, frame_done_d;
  logic            start, bus_done, wr_ok, row_ready;
  logic [9:0]      word;
  logic [7:0]      buf_q [ROWS][COLS];

  // A clear in the same cycle drops the write; out-of-range writes are ignored.
  assign wr_ok = wr_en && !clear && (32'(wr_row) < ROWS) && (32'(wr_col) < COLS);

  // Frame buffer: clear fills with spaces, otherwise single-cell writes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned r = 0; r < ROWS; r++)
        for (int unsigned c = 0; c < COLS; c++) buf_q[r][c] <= 8'h20;
    end else if (clear) begin
      for (int unsigned r = 0; r < ROWS; r++)
        for (int unsigned c = 0; c < COLS; c++) buf_q[r][c] <= 8'h20;
    end else if (wr_ok) begin
      buf_q[wr_row][wr_col] <= wr_char;
    end
  end

`ifdef LCD_DIRTY_SKIP_EN
  logic [ROWS-1:0] dirty_q, dirty_d;
  logic            wrote_q, wrote_d;

  assign row_ready = dirty_q[row_q];

  // Dirty bits: cleared as a row's address transaction starts; a set wins.
  always_comb begin
    dirty_d = dirty_q;
    if (start && state_q == S_ADDR) dirty_d[row_q] = 1'b0;
    if (clear) dirty_d = '1;
    else if (wr_ok) dirty_d[wr_row] = 1'b1;
  end

  // Dirty tracking registers; everything is stale after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dirty_q <= '1;
      wrote_q <= 1'b0;
    end else begin
      dirty_q <= dirty_d;
      wrote_q <= wrote_d;
    end
  end
`else
  assign row_ready = 1'b1;
`endif

  // FSM state and sequencing registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_PWRUP;
      ret_q        <= S_INIT;
      pwr_cnt_q    <= '0;
      init_idx_q   <= '0;
      row_q        <= '0;
      col_q        <= '0;
      init_done_q  <= 1'b0;
      frame_pend_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ret_q        <= ret_d;
      pwr_cnt_q    <= pwr_cnt_d;
      init_idx_q   <= init_idx_d;
      row_q        <= row_d;
      col_q        <= col_d;
      init_done_q  <= init_done_d;
      frame_pend_q <= frame_pend_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Next-state: issue states hand one word to the timer, then park in S_WAIT.
  always_comb begin
    state_d      = state_q;
    ret_d        = ret_q;
    pwr_cnt_d    = pwr_cnt_q;
    init_idx_d   = init_idx_q;
    row_d        = row_q;
    col_d        = col_q;
    init_done_d  = init_done_q;
    frame_pend_d = frame_pend_q;
    frame_done_d = 1'b0;
`ifdef LCD_DIRTY_SKIP_EN
    wrote_d      = wrote_q;
`endif
    case (state_q)
      S_PWRUP: begin
        if (32'(pwr_cnt_q) + 32'd1 >= POWERUP_CYC) state_d = S_INIT;
        else pwr_cnt_d = pwr_cnt_q + PwrW'(1);
      end
      S_INIT: begin
        state_d    = S_WAIT;
        init_idx_d = init_idx_q + 3'd1;
        ret_d      = (init_idx_q == 3'(NUM_INIT_CMDS - 1)) ? S_ADDR : S_INIT;
      end
      S_ADDR: begin
        // Registered so init_done lands on the first address transaction.
        init_done_d = 1'b1;
        if (frame_pend_q) begin
          frame_done_d = 1'b1;
          frame_pend_d = 1'b0;
        end
        if (row_ready) begin
          state_d = S_WAIT;
          ret_d   = S_CHAR;
          col_d   = '0;
`ifdef LCD_DIRTY_SKIP_EN
          wrote_d = 1'b1;
        end else if (row_q == RowLast) begin
          row_d        = '0;
          frame_pend_d = wrote_q;
          wrote_d      = 1'b0;
        end else begin
          row_d = row_q + RowW'(1);
`endif
        end
      end
      S_CHAR: begin
        state_d = S_WAIT;
        if (col_q == ColLast) begin
          ret_d = S_ADDR;
          col_d = '0;
          if (row_q == RowLast) begin
            row_d        = '0;
            frame_pend_d = 1'b1;
`ifdef LCD_DIRTY_SKIP_EN
            wrote_d      = 1'b0;
`endif
          end else begin
            row_d = row_q + RowW'(1);
          end
        end else begin
          ret_d = S_CHAR;
          col_d = col_q + ColW'(1);
        end
      end
      S_WAIT: begin
        if (bus_done) state_d = ret_q;
      end
      default: state_d = S_PWRUP;
    endcase
  end

  // Outputs: start pulse and the bus word for the current issue state.
  always_comb begin
    start = 1'b0;
    word  = '0;
    case (state_q)
      S_INIT: begin
        start = 1'b1;
        word  = init_cmd(init_idx_q);
      end
      S_ADDR: begin
        start         = row_ready;
        word[7]       = 1'b1;
        word[6:0]     = row_base(2'(row_q));
      end
      S_CHAR: begin
        start         = 1'b1;
        word[RS_BIT]  = 1'b1;
        word[RW_BIT]  = 1'b0;
        word[7:0]     = buf_q[row_q][col_q];
      end
      default: ;
    endcase
  end

  lcd_bus_timer #(
    .CMD_WAIT_CYC (CMD_WAIT_CYC),
    .EN_PULSE_CYC (EN_PULSE_CYC)
  ) u_bus_timer (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .word     (word),
    .lcd_en   (lcd_en),
    .lcd_flag (lcd_flag),
    .done     (bus_done)
  );

  assign lcd_on     = 1'b1;
  assign init_done  = init_done_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_lcd_text_engine.sv
// Self-checking bench for lcd_text_engine: cycle-level reference model of the
// bus schedule plus directed and randomized buffer writes.
module tb_lcd_text_engine;

  localparam int ROWS = 2;
  localparam int COLS = 4;
  localparam int PWR  = 20;
  localparam int WAIT = 8;
  localparam int EN   = 2;
  localparam int FR   = ROWS * (COLS + 1);

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_en = 1'b0;
  logic       clear = 1'b0;
  logic [0:0] wr_row = '0;
  logic [1:0] wr_col = '0;
  logic [7:0] wr_char = '0;
  logic       lcd_on, lcd_en, init_done, frame_done;
  logic [9:0] lcd_flag;

  int         errors = 0;
  int         checks = 0;
  int         n = 0;
  logic [9:0] latched = '0;
  logic [7:0] mbuf [ROWS][COLS];
  logic [9:0] init_tab [6] = '{10'h038, 10'h038, 10'h008, 10'h001, 10'h00C, 10'h006};
  int         base_tab [4] = '{'h00, 'h40, 'h14, 'h54};

  lcd_text_engine #(
    .ROWS         (ROWS),
    .COLS         (COLS),
    .POWERUP_CYC  (PWR),
    .CMD_WAIT_CYC (WAIT),
    .EN_PULSE_CYC (EN)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_row     (wr_row),
    .wr_col     (wr_col),
    .wr_char    (wr_char),
    .clear      (clear),
    .lcd_on     (lcd_on),
    .lcd_en     (lcd_en),
    .lcd_flag   (lcd_flag),
    .init_done  (init_done),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, n, act, exp);
    end
  endtask

  task automatic reset_model();
    n = 0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) mbuf[r][c] = 8'h20;
  endtask

  // k-th bus word since reset: init list, then address + characters per row.
  function automatic logic [9:0] seq_word(input int k);
    int j, r, c;
    if (k < 6) return init_tab[k];
    j = (k - 6) % FR;
    r = j / (COLS + 1);
    c = j % (COLS + 1);
    if (c == 0) return 10'(32'h080 + base_tab[r]);
    return {2'b10, mbuf[r][c-1]};
  endfunction

  task automatic idle_inputs();
    wr_en = 1'b0;
    clear = 1'b0;
  endtask

`ifndef LCD_DIRTY_SKIP_EN
  // One clock: compare every output to the model, then commit this edge's write.
  task automatic step();
    int k, ph;
    logic [13:0] exp;
    @(posedge clk);
    #1;
    n++;
    if (n <= PWR) begin
      exp = {1'b1, 1'b0, 1'b0, 1'b0, 10'h000};
    end else begin
      k  = (n - PWR - 1) / WAIT;
      ph = (n - PWR - 1) % WAIT;
      if (ph == 0) latched = seq_word(k);
      exp = {1'b1, ph < EN, n >= PWR + 6 * WAIT + 1,
             ph == 0 && k >= 6 + FR && (k - 6) % FR == 0, latched};
    end
    check("bus", {lcd_on, lcd_en, init_done, frame_done, lcd_flag}, 32'(exp));
    if (clear) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) mbuf[r][c] = 8'h20;
    end else if (wr_en) begin
      mbuf[wr_row][wr_col] = wr_char;
    end
  endtask

  // Hand-computed expectations that pin the model's schedule.
  task automatic pins();
    if (n == 20) check("pwrup_en_low", lcd_en, 0);
    if (n == 21) check("first_cmd", lcd_flag, 10'h038);
    if (n == 22) check("en_second_cycle", lcd_en, 1);
    if (n == 23) check("en_falls", lcd_en, 0);
    if (n == 45) check("clear_cmd", lcd_flag, 10'h001);
    if (n == 61) check("entry_cmd", lcd_flag, 10'h006);
    if (n == 68) check("init_not_yet", init_done, 0);
    if (n == 69) check("init_done", init_done, 1);
    if (n == 69) check("row0_addr", lcd_flag, 10'h080);
    if (n == 77) check("blank_char", lcd_flag, 10'h220);
    if (n == 109) check("row1_addr", lcd_flag, 10'h0C0);
    if (n == 148) check("no_early_frame_done", frame_done, 0);
    if (n == 149) check("frame_done", frame_done, 1);
    if (n == 213) check("single_write", lcd_flag, 10'h241);
    if (n == 293) check("clear_beats_write", lcd_flag, 10'h220);
  endtask

  task automatic run_to(input int last);
    while (n < last) begin
      step();
      pins();
    end
  endtask
`endif

  initial begin
    reset_model();
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {lcd_on, lcd_en, init_done, frame_done, lcd_flag}, 32'h2000);
    @(negedge clk);
    reset = 1'b1;

`ifndef LCD_DIRTY_SKIP_EN
    run_to(160);
    wr_en = 1'b1; wr_row = 1'b1; wr_col = 2'd2; wr_char = 8'h41;
    step();
    idle_inputs();
    run_to(220);
    wr_en = 1'b1; clear = 1'b1; wr_row = 1'b1; wr_col = 2'd2; wr_char = 8'h55;
    step();
    idle_inputs();
    run_to(300);

    for (int i = 0; i < 1200; i++) begin
      wr_en   = ($urandom_range(3) == 0);
      clear   = ($urandom_range(39) == 0);
      wr_row  = 1'($urandom_range(1));
      wr_col  = 2'($urandom_range(3));
      wr_char = 8'($urandom_range(255));
      step();
    end
    idle_inputs();

    // Land on the first cycle of a transaction, then reset mid-enable.
    for (int i = 0; i < WAIT && ((n - PWR - 1) % WAIT) != 0; i++) step();
    check("en_before_reset", lcd_en, 1);
    #1;
    reset = 1'b0;
    #1;
    check("async_reset", {lcd_on, lcd_en, init_done, frame_done, lcd_flag}, 32'h2000);
    @(negedge clk);
    reset = 1'b1;
    reset_model();
    run_to(120);
`else
    begin
      logic [9:0] got [$];
      logic [9:0] exp_q [$];
      logic       prev_en;
      int         fd_cnt;
      prev_en = 1'b0;
      fd_cnt  = 0;
      for (int i = 0; i < 200; i++) begin
        @(posedge clk); #1;
        if (lcd_en && !prev_en) got.push_back(lcd_flag);
        if (frame_done) fd_cnt++;
        prev_en = lcd_en;
      end
      for (int k = 0; k < 6 + FR; k++) exp_q.push_back(seq_word(k));
      wr_en = 1'b1; wr_row = 1'b0; wr_col = 2'd1; wr_char = 8'h5A;
      @(posedge clk); #1;
      idle_inputs();
      mbuf[0][1] = 8'h5A;
      for (int k = 6; k < 6 + COLS + 1; k++) exp_q.push_back(seq_word(k));
      for (int i = 0; i < 120; i++) begin
        @(posedge clk); #1;
        if (lcd_en && !prev_en) got.push_back(lcd_flag);
        if (frame_done) fd_cnt++;
        prev_en = lcd_en;
      end
      check("dirty_txn_count", got.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got.size(); i++)
        check("dirty_txn_word", got[i], exp_q[i]);
      check("dirty_frame_done_count", fd_cnt, 2);
      check("dirty_idle_en", lcd_en, 0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lcd_text_engine.md
# lcd_text_engine

Parametrised HD44780-class character-LCD driver that succeeds the fixed 16x2 game-state display. Game logic writes individual characters into an internal ROWS x COLS frame buffer through a single-cycle write port. The block handles power-up, the controller init sequence and continuous screen refresh on its own. It sits between the game FSM and the on-board LCD pins.

## Interface
Parameters:
- `ROWS`, default 2: display rows; legal range 1..4.
- `COLS`, default 16: display columns; legal range 1..40; ROWS*COLS ≤ 80.
- `POWERUP_CYC`, default 2250000: idle cycles after reset before the first command (45 ms at 50 MHz).
- `CMD_WAIT_CYC`, default 100000: total cycles per bus transaction (2 ms at 50 MHz).
- `EN_PULSE_CYC`, default 25: cycles `lcd_en` is high at the start of each transaction; 1 ≤ EN_PULSE_CYC < CMD_WAIT_CYC.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-low reset.
- `wr_en` in 1: write one character into the buffer this cycle.
- `wr_row` in max(1,$clog2(ROWS)): target row.
- `wr_col` in max(1,$clog2(COLS)): target column.
- `wr_char` in 8: ASCII code.
- `clear` in 1: one-cycle pulse; sets every cell to 0x20.
- `lcd_on` out 1: LCD power.
- `lcd_en` out 1: LCD enable strobe.
- `lcd_flag` out 10: {RS, RW, DB7..DB0}.
- `init_done` out 1: high once the init sequence has completed.
- `frame_done` out 1: one-cycle pulse at the end of each refresh pass.

## Operation
Reset values:
- `lcd_on`=1, `lcd_en`=0, `lcd_flag`=0, `init_done`=0, `frame_done`=0.
- All buffer cells = 0x20; FSM in S_PWRUP.

Buffer write rules:
- Writes are always accepted and never back-pressured.
- Writes with `wr_row`≥ROWS or `wr_col`≥COLS are ignored.
- If `clear` and `wr_en` are asserted together, `clear` wins and the write is dropped.

FSM:
- **S_PWRUP**: count POWERUP_CYC cycles, then go to S_INIT.
- **S_INIT**: issue six commands in order, each as one transaction:
  - 0x038 (function set), 0x038 (function set)
  - 0x008 (display off), 0x001 (clear)
  - 0x00C (display on, cursor off), 0x006 (entry mode, increment)
  - After the last command: set `init_done`=1 (it stays set until reset), then go to S_ADDR with row=0.
- **S_ADDR**: issue the DDRAM address command {2'b00, 1'b1, ROW_BASE[row]}. ROW_BASE = 0x00, 0x40, 0x14, 0x54. Then go to S_CHAR with col=0.
- **S_CHAR**: issue {2'b10, buf[row][col]} per column.
  - After col=COLS-1: advance to the next row and return to S_ADDR.
  - After the last row: pulse `frame_done`, wrap to row 0 and return to S_ADDR.
- Every transaction goes through S_WAIT, which the shared bus timer drives.
- The character byte is sampled from the buffer at transaction start. A write landing mid-transaction appears on the next pass.
- RW is always 0; the busy flag is never read.

## Timing
- Transaction start cycle t0: `lcd_flag` is loaded and `lcd_en` rises.
- `lcd_en` stays high for cycles t0..t0+EN_PULSE_CYC-1, then is low until t0+CMD_WAIT_CYC-1.
- `lcd_flag` is held stable for the whole transaction.
- The next transaction starts at t0+CMD_WAIT_CYC, so transactions are back-to-back with no gap cycles.
- Time from `reset` release to the first `lcd_en` rise = POWERUP_CYC cycles.
- `init_done` rises on the cycle after the 6th transaction ends.
- Full refresh pass = ROWS*(COLS+1)*CMD_WAIT_CYC cycles.
- `frame_done` is asserted on the first cycle of the following S_ADDR transaction.
- Reset asserted mid-transaction: all outputs go to their reset values immediately, and the sequence restarts from S_PWRUP.

## Configuration
- `LCD_DIRTY_SKIP_EN` defined:
  - Each row has a dirty bit.
  - A write or `clear` sets the bit(s); the bit clears when that row's S_ADDR transaction starts.
  - If a set and a clear happen in the same cycle, the set wins.
  - S_ADDR skips clean rows with zero transactions.
  - If all rows are clean, the FSM idles in S_ADDR with `lcd_en`=0. `frame_done` still pulses once per completed scan that wrote at least one row.
  - All rows are dirty after reset.
- Not defined: all rows are refreshed continuously; no dirty logic is present.

## Structure
- Package `lcd_pkg` holds:
  - the init command constants;
  - the ROW_BASE table;
  - the state enum {S_PWRUP, S_INIT, S_ADDR, S_CHAR, S_WAIT};
  - the RS/RW field positions.
- Sub-module `lcd_bus_timer` handles transaction timing:
  - inputs: `start` and a 10-bit word;
  - outputs: `lcd_en`, `lcd_flag` and a `done` pulse;
  - it owns the EN_PULSE_CYC / CMD_WAIT_CYC counter.

## Test plan
Bench parameters: ROWS=2, COLS=4, POWERUP_CYC=20, CMD_WAIT_CYC=8, EN_PULSE_CYC=2.
- **Reset and power-up**: release reset → `lcd_en` stays 0 for 20 cycles. Then the bus shows 0x038, 0x038, 0x008, 0x001, 0x00C, 0x006, 8 cycles apart, with `lcd_en` high 2 cycles each. `init_done`=1 after 68 cycles.
- **Default frame**: no writes → bus shows 0x080, then 0x220 ×4, then 0x0C0, then 0x220 ×4. `frame_done` pulses every 80 cycles.
- **Single write**: write row1/col2 = 0x41 → the next pass shows 0x241 as the 3rd character after 0x0C0.
- **Out-of-range and collision**: write col=5 → ignored. `wr_en` together with `clear` → that cell reads 0x20.
- **Async reset**: assert `reset` at mid-`lcd_en` → `lcd_en`=0 and `lcd_flag`=0 in the same cycle. The power-up and init sequence then restart.
- **Dirty skip** (`LCD_DIRTY_SKIP_EN` build): after the first full frame, write row 0 only → the bus shows 0x080 plus 4 characters, then goes idle, with no 0x0C0.
